// File: rtl/dg0045_ram_arbiter.sv
// Host/CPU arbiter for a shared 64x4 RAM port: CPU has absolute priority, host uses a 4-phase handshake.
// Optional build macro RAM_ARB_HOLD_EN adds a wait counter and a cpu_hold request after a long host stall.
module dg0045_ram_arbiter (
    input  logic       clk_in,
    input  logic       RESET,
    input  logic       cpu_win,
    input  logic [5:0] cpu_addr,
    input  logic [3:0] cpu_din,
    input  logic       cpu_we,
    output logic       cpu_hold,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [5:0] host_addr,
    input  logic [3:0] host_din,
    output logic       host_ack,
    output logic [3:0] host_dout,
    output logic [5:0] ram_addr,
    output logic [3:0] ram_din,
    output logic       ram_we,
    input  logic [3:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [3:0] din;
    } host_hold_t;

    state_t     state;
    host_hold_t hreq;
    logic       grant;

    // Host owns the port only in ACCESS on a cycle the CPU leaves free.
    assign grant = (state == ACCESS) && !cpu_win;

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            hreq      <= '0;
            host_ack  <= 1'b0;
            host_dout <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_req) begin
                        hreq  <= '{we: host_we, addr: host_addr, din: host_din};
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (grant) begin
                        host_dout <= ram_dout;
                        host_ack  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!host_req) begin
                        host_ack <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    host_ack <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        if (cpu_win) begin
            ram_we = cpu_we;
        end else if (state == ACCESS) begin
            ram_addr = hreq.addr;
            ram_din  = hreq.din;
            ram_we   = hreq.we;
        end
    end

`ifdef RAM_ARB_HOLD_EN
    logic [3:0] wait_cnt;
    logic [3:0] wait_inc;
    logic       hold_r;

    assign wait_inc = (wait_cnt == 4'hF) ? 4'hF : wait_cnt + 4'h1;
    assign cpu_hold = hold_r;

    // hold_r is set on the same edge the counter reaches 15 so it tracks the count.
    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            wait_cnt <= 4'h0;
            hold_r   <= 1'b0;
        end else begin
            hold_r <= 1'b0;
            if (state == IDLE && host_req) begin
                wait_cnt <= 4'h0;
            end else if (state == ACCESS && cpu_win) begin
                wait_cnt <= wait_inc;
                hold_r   <= (wait_inc == 4'hF);
            end
        end
    end
`else
    assign cpu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// Directed self-checking bench for dg0045_ram_arbiter with a behavioural 64x4 RAM.
module tb_dg0045_ram_arbiter;

    logic       clk_in = 1'b0;
    logic       RESET;
    logic       cpu_win;
    logic [5:0] cpu_addr;
    logic [3:0] cpu_din;
    logic       cpu_we;
    logic       cpu_hold;
    logic       host_req;
    logic       host_we;
    logic [5:0] host_addr;
    logic [3:0] host_din;
    logic       host_ack;
    logic [3:0] host_dout;
    logic [5:0] ram_addr;
    logic [3:0] ram_din;
    logic       ram_we;
    logic [3:0] ram_dout;

    logic [3:0] mem [64];
    int checks = 0;
    int errors = 0;
    logic exp_hold;

    dg0045_ram_arbiter dut (
        .clk_in(clk_in), .RESET(RESET),
        .cpu_win(cpu_win), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_hold(cpu_hold),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
        .host_ack(host_ack), .host_dout(host_dout),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk_in = ~clk_in;

    assign ram_dout = mem[ram_addr];
    always @(posedge clk_in) if (ram_we) mem[ram_addr] <= ram_din;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        RESET = 1'b0; cpu_win = 1'b0; cpu_addr = 6'h00; cpu_din = 4'h0; cpu_we = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 6'h00; host_din = 4'h0;
        #2;
        chk("rst_ack", host_ack, 0);
        chk("rst_dout", host_dout, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_we_idle", ram_we, 0);
        cpu_win = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h3F; cpu_din = 4'h5;
        #1;
        chk("rst_cpu_we", ram_we, 1);
        chk("rst_cpu_addr", ram_addr, 8'h3F);
        cpu_we = 1'b0;
        #1;
        chk("rst_cpu_we0", ram_we, 0);
        tick();
        cpu_win = 1'b0; RESET = 1'b1;
        tick();

        // host write 2A <= 9
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'h2A; host_din = 4'h9;
        #1;
        chk("w_idle_we", ram_we, 0);
        tick();
        host_din = 4'h3; host_addr = 6'h01;
        #1;
        chk("w_acc_we", ram_we, 1);
        chk("w_acc_addr", ram_addr, 8'h2A);
        chk("w_acc_din", ram_din, 8'h9);
        chk("w_acc_ack", host_ack, 0);
        tick();
        chk("w_ack", host_ack, 1);
        chk("w_we_done", ram_we, 0);
        chk("w_mem", mem[6'h2A], 8'h9);
        chk("w_dout_old", host_dout, 0);
        host_req = 1'b0;
        tick();
        chk("w_ack_drop", host_ack, 0);

        // host read 2A
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'h2A;
        tick();
        chk("r_acc_we", ram_we, 0);
        chk("r_acc_addr", ram_addr, 8'h2A);
        tick();
        chk("r_ack", host_ack, 1);
        chk("r_dout", host_dout, 8'h9);
        chk("r_mem", mem[6'h2A], 8'h9);
        host_req = 1'b0;
        tick();

        // CPU steals 3 cycles during host write 10 <= C
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'h10; host_din = 4'hC;
        tick();
        for (int i = 1; i <= 3; i++) begin
            cpu_win = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h10 + 6'(i); cpu_din = 4'(i);
            #1;
            chk("c_cpu_addr", ram_addr, 8'h10 + 8'(i));
            chk("c_cpu_we", ram_we, 1);
            tick();
            chk("c_ack_wait", host_ack, 0);
        end
        cpu_win = 1'b0; cpu_we = 1'b0;
        #1;
        chk("c_host_addr", ram_addr, 8'h10);
        chk("c_host_din", ram_din, 8'hC);
        chk("c_host_we", ram_we, 1);
        tick();
        chk("c_ack", host_ack, 1);
        chk("c_mem10", mem[6'h10], 8'hC);
        chk("c_mem11", mem[6'h11], 8'h1);
        chk("c_mem12", mem[6'h12], 8'h2);
        chk("c_mem13", mem[6'h13], 8'h3);
        host_req = 1'b0;
        tick();

        // 20 CPU cycles during host read of 11
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'h11;
        tick();
        cpu_win = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h00;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef RAM_ARB_HOLD_EN
            exp_hold = (i >= 15);
`else
            exp_hold = 1'b0;
`endif
            chk("h_hold", cpu_hold, exp_hold);
            chk("h_ack_wait", host_ack, 0);
        end
        cpu_win = 1'b0;
        tick();
        chk("h_ack", host_ack, 1);
        chk("h_dout", host_dout, 8'h1);
        chk("h_hold_drop", cpu_hold, 0);
        host_req = 1'b0;
        tick();

        // reset during a pending host write 20 <= F
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'h20; host_din = 4'hF;
        tick();
        chk("x_acc_we", ram_we, 1);
        RESET = 1'b0;
        #1;
        chk("x_rst_we", ram_we, 0);
        chk("x_rst_dout", host_dout, 0);
        tick();
        host_req = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        chk("x_we_after", ram_we, 0);
        chk("x_ack_after", host_ack, 0);
        tick();
        chk("x_mem20", mem[6'h20], 8'h0);
        chk("x_ack_idle", host_ack, 0);

        // host_req held through DONE; no second access
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'h2A;
        tick();
        tick();
        chk("d_ack", host_ack, 1);
        chk("d_dout", host_dout, 8'h9);
        host_we = 1'b1; host_din = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("d_ack_hold", host_ack, 1);
            chk("d_we_hold", ram_we, 0);
        end
        host_req = 1'b0;
        tick();
        chk("d_ack_drop", host_ack, 0);
        tick();
        chk("d_idle_we", ram_we, 0);
        chk("d_mem", mem[6'h2A], 8'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
